div_iter: RTL
=============

// Module: div_iter
// PURPOSE
//  Multi-cycle 32-bit integer divider for the EXE stage (DIV/DIVU); the inverse of the 32-bit CLA add path.
//  Radix-2 restoring algorithm, one quotient bit per cycle.
//  Each trial subtraction uses one instance of the 32-bit CLA adder (operand2 = ~divisor, cin = 1).
//  The pipeline stalls while div_busy is high and writes quotient to LO and remainder to HI on div_done.
// PARAMETERS
//  WIDTH     32   operand width; 32 is the only legal value (the adder is fixed at 32 bits)
//  CNT_W     5    iteration counter width; localparam, $clog2(WIDTH)
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  div_start    in   1   request; sampled only in IDLE
//  div_signed   in   1   1 = signed (DIV), 0 = unsigned (DIVU); sampled with div_start
//  div_cancel   in   1   pipeline flush; aborts the operation in progress
//  div_op1      in   32  dividend, sampled with div_start
//  div_op2      in   32  divisor, sampled with div_start
//  div_busy     out  1   high in CALC and DONE; pipeline stall request
//  div_done     out  1   one-cycle pulse; quotient/remainder valid from this cycle
//  quotient     out  32  registered result, held until the next completed operation
//  remainder    out  32  registered result, held until the next completed operation
// BEHAVIOUR
//  Reset: state = IDLE; div_busy, div_done = 0; quotient, remainder = 0; internal regs = 0.
//  FSM states (IDLE, CALC, DONE)
//   IDLE -> CALC: div_start=1 and div_cancel=0 at a clock edge (cycle N).
//    Latches |op1|, |op2| (abs only when signed), the sign flags, op1 and a zero-divisor flag.
//    Clears the partial remainder and sets cnt = 0.
//   CALC -> CALC: cnt < 31; one iteration per cycle, cycles N+1..N+32.
//   CALC -> DONE: cnt == 31.
//   DONE -> IDLE: always. div_done = 1 in cycle N+33; the result registers update on entry to DONE.
//   Any state -> IDLE: div_cancel = 1, effective next cycle.
//    No div_done; quotient/remainder keep their previous values.
//    Cancel wins over a simultaneous start.
//  div_start outside IDLE is ignored; there is no queueing.
//  Iteration step
//   rs = {rem[31:0], dvd[31]} (33 bits).
//   Adder computes rs[31:0] + ~dvs + 1 and produces cout.
//   qbit = rs[32] | cout.
//   rem <= qbit ? sum : rs[31:0].
//   dvd <= {dvd[30:0], qbit}; the dividend register accumulates the quotient.
//  Sign fix-up (signed only)
//   Quotient is negated when op1 and op2 signs differ.
//   Remainder takes the sign of the dividend.
//   Negation is two's complement; a second adder instance or an inline incrementer is allowed.
//  Boundaries
//   Divisor = 0: quotient = 32'hFFFFFFFF and remainder = the original div_op1, for signed and unsigned.
//    Still takes the full latency.
//   0x80000000 / 0xFFFFFFFF (signed): quotient = 0x80000000, remainder = 0; no trap.
//   |op1| of 0x80000000 is treated as unsigned 2^31.
//   Dividend < divisor: quotient = 0, remainder = dividend.
//  Latency is fixed at 33 cycles from the start edge to div_done; there is no early termination.
//  Asynchronous rst mid-operation returns to IDLE immediately and clears all outputs.
// STRUCTURE
//  Shared header div_defs.vh: state encodings DIV_IDLE/DIV_CALC/DIV_DONE, DIV_WIDTH = 32, DIV_LAT = 33.
//  Sub-module: one instance of the existing 32-bit CLA adder (adder) for the trial subtraction.
//  Everything else is inline: FSM, counter, shift registers and sign fix-up.
// TESTING
//  1. DIVU 100 / 7, start in cycle N -> busy from N+1; done in N+33 only; q = 14, r = 2.
//  2. DIV 0xFFFFFFF9 / 2 (-7/2) -> q = 0xFFFFFFFD (-3), r = 0xFFFFFFFF (-1).
//     Also 7 / -2 -> q = -3, r = 1.
//  3. DIVU 0x1234 / 0 and DIV 0xFFFFFFF0 / 0 -> q = 0xFFFFFFFF with r = dividend in both cases; done at N+33.
//  4. DIV 0x80000000 / 0xFFFFFFFF -> q = 0x80000000, r = 0.
//     DIVU 0xFFFFFFFF / 1 -> q = 0xFFFFFFFF, r = 0.
//  5. Start in N, div_cancel in N+10 -> IDLE in N+11; no done pulse.
//     q/r keep the previous results; a new start in N+11 completes normally.
//  6. rst asserted mid-CALC -> outputs 0 immediately.
//     div_start during CALC and cancel+start in IDLE are both ignored.
//     Random signed/unsigned sweep against the $signed / and % model.

Source files
------------

// File: rtl/div_iter_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_iter_pkg;

  localparam int unsigned DivWidth = 32;
  localparam int unsigned DivLat   = 33;
  localparam int unsigned DivCntW  = $clog2(DivWidth);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } div_state_e;

  function automatic logic [DivWidth-1:0] twos_neg(input logic [DivWidth-1:0] x);
    return ~x + DivWidth'(1);
  endfunction

  // Magnitude of a two's complement value; 0x80000000 maps to unsigned 2^31.
  function automatic logic [DivWidth-1:0] cond_abs(input logic [DivWidth-1:0] x,
                                                   input logic              en);
    return (en && x[DivWidth-1]) ? twos_neg(x) : x;
  endfunction

endpackage

// File: rtl/div_iter_adder.sv
// Carry-lookahead adder built from 4-bit lookahead groups with a group carry chain.
module div_iter_adder #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             cin_i,
  output logic [Width-1:0] sum_o,
  output logic             cout_o
);

  localparam int unsigned NumGrp = Width / 4;

  logic [Width-1:0] gen;
  logic [Width-1:0] prop;
  logic [Width-1:0] carry;
  logic [3:0]       gl;
  logic [3:0]       pl;
  logic             gg;
  logic             gp;
  logic             cg;

  assign gen  = a_i & b_i;
  assign prop = a_i ^ b_i;

  always_comb begin
    carry = '0;
    gl    = '0;
    pl    = '0;
    gg    = 1'b0;
    gp    = 1'b0;
    cg    = cin_i;
    for (int gi = 0; gi < int'(NumGrp); gi++) begin
      gl = gen[4*gi +: 4];
      pl = prop[4*gi +: 4];
      gg = gl[3] | (pl[3] & gl[2]) | (pl[3] & pl[2] & gl[1]) | (pl[3] & pl[2] & pl[1] & gl[0]);
      gp = &pl;
      carry[4*gi]     = cg;
      carry[4*gi + 1] = gl[0] | (pl[0] & cg);
      carry[4*gi + 2] = gl[1] | (pl[1] & gl[0]) | (pl[1] & pl[0] & cg);
      carry[4*gi + 3] = gl[2] | (pl[2] & gl[1]) | (pl[2] & pl[1] & gl[0]) |
                        (pl[2] & pl[1] & pl[0] & cg);
      cg = gg | (gp & cg);
    end
  end

  assign sum_o  = prop ^ carry;
  assign cout_o = cg;

endmodule

// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU), one quotient bit per cycle,
// fixed 33-cycle latency from the start edge to the done pulse.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int unsigned Width = DivWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic             div_cancel,
  input  logic [Width-1:0] div_op1,
  input  logic [Width-1:0] div_op2,
  output logic             div_busy,
  output logic             div_done,
  output logic [Width-1:0] quotient,
  output logic [Width-1:0] remainder
);

  localparam int unsigned CntW    = $clog2(Width);
  localparam logic [CntW-1:0] LastCnt = CntW'(DivLat - 2);

  div_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [Width-1:0] dvd_q, dvd_d;
  logic [Width-1:0] dvs_q, dvs_d;
  logic [Width-1:0] rem_q, rem_d;
  logic [Width-1:0] op1_q, op1_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             zero_q, zero_d;
  logic [Width-1:0] quotient_q, quotient_d;
  logic [Width-1:0] remainder_q, remainder_d;

  logic [Width:0]   rs;
  logic [Width-1:0] diff;
  logic             cout;
  logic             qbit;
  logic [Width-1:0] rem_nxt;
  logic [Width-1:0] quo_nxt;

  // Trial subtraction: shifted partial remainder minus divisor.
  assign rs = {rem_q, dvd_q[Width-1]};

  div_iter_adder #(
    .Width (Width)
  ) u_adder (
    .a_i    (rs[Width-1:0]),
    .b_i    (~dvs_q),
    .cin_i  (1'b1),
    .sum_o  (diff),
    .cout_o (cout)
  );

  assign qbit    = rs[Width] | cout;
  assign rem_nxt = qbit ? diff : rs[Width-1:0];
  assign quo_nxt = {dvd_q[Width-2:0], qbit};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    op1_d       = op1_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    zero_d      = zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    unique case (state_q)
      StIdle: begin
        if (div_start) begin
          state_d   = StCalc;
          cnt_d     = '0;
          rem_d     = '0;
          dvd_d     = cond_abs(div_op1, div_signed);
          dvs_d     = cond_abs(div_op2, div_signed);
          op1_d     = div_op1;
          neg_quo_d = div_signed & (div_op1[Width-1] ^ div_op2[Width-1]);
          neg_rem_d = div_signed & div_op1[Width-1];
          zero_d    = (div_op2 == '0);
        end
      end
      StCalc: begin
        rem_d = rem_nxt;
        dvd_d = quo_nxt;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          // Divide-by-zero overrides the sign fix-up so both flavours agree.
          if (zero_q) begin
            quotient_d  = '1;
            remainder_d = op1_q;
          end else begin
            quotient_d  = neg_quo_q ? twos_neg(quo_nxt) : quo_nxt;
            remainder_d = neg_rem_q ? twos_neg(rem_nxt) : rem_nxt;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (div_cancel) begin
      state_d     = StIdle;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      op1_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      zero_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      op1_q       <= op1_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      zero_q      <= zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign div_busy  = (state_q != StIdle);
  assign div_done  = (state_q == StDone);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule
